// File: rtl/lsu_controller.sv
// RV32I load/store controller: one outstanding bus access, registered bus outputs, ack timeout.
// Accept in IDLE, mem_req one cycle later; req_ready is low whenever a request is in flight.
module lsu_controller #(
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        is_store,
  input  logic [2:0]  func3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [4:0]  rd_addr,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        done,
  output logic        stall,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic [31:0] bad_addr
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_FAULT} state_t;

  localparam logic [7:0] TIMEOUT = 8'(ACK_TIMEOUT);

  state_t      state;
  logic [7:0]  cnt;
  logic        lat_store;
  logic [2:0]  lat_func3;
  logic [31:0] lat_addr;
  logic [4:0]  lat_rd;

  logic        illegal;
  logic        misaligned;
  logic [3:0]  dec_be;
  logic [31:0] dec_wdata;

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  assign req_ready = (state == S_IDLE);
  assign stall     = (state != S_IDLE);

  // Decode straight from the request inputs so the accept cycle already knows the next state.
  always_comb begin
    illegal    = is_store ? (func3 > 3'd2) : ((func3 == 3'b011) || (func3[2:1] == 2'b11));
    misaligned = 1'b0;
    dec_be     = 4'b1111;
    dec_wdata  = wdata;
    case (func3[1:0])
      2'b00: begin
        dec_be    = 4'b0001 << addr[1:0];
        dec_wdata = {4{wdata[7:0]}};
      end
      2'b01: begin
        misaligned = addr[0];
        dec_be     = addr[1] ? 4'b1100 : 4'b0011;
        dec_wdata  = {2{wdata[15:0]}};
      end
      default: begin
        misaligned = |addr[1:0];
      end
    endcase
    if (!is_store) dec_wdata = '0;
  end

  always_comb begin
    ld_byte = mem_rdata[{lat_addr[1:0], 3'b000} +: 8];
    ld_half = lat_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (lat_func3)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      lat_store   <= 1'b0;
      lat_func3   <= '0;
      lat_addr    <= '0;
      lat_rd      <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_be      <= '0;
      wb_valid    <= 1'b0;
      wb_rd       <= '0;
      wb_data     <= '0;
      done        <= 1'b0;
      fault       <= 1'b0;
      fault_cause <= '0;
      bad_addr    <= '0;
    end else begin
      done     <= 1'b0;
      fault    <= 1'b0;
      wb_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            lat_store <= is_store;
            lat_func3 <= func3;
            lat_addr  <= addr;
            lat_rd    <= rd_addr;
            if (illegal || misaligned) begin
              state       <= S_FAULT;
              fault       <= 1'b1;
              done        <= 1'b1;
              fault_cause <= illegal ? 2'b10 : 2'b01;
              bad_addr    <= addr;
            end else begin
              state     <= S_REQ;
              cnt       <= '0;
              mem_req   <= 1'b1;
              mem_we    <= is_store;
              mem_addr  <= {addr[31:2], 2'b00};
              mem_be    <= dec_be;
              mem_wdata <= dec_wdata;
            end
          end
        end
        S_REQ: begin
          // An ack in the final allowed cycle wins over the timeout.
          if (mem_ack || (cnt + 8'd1 == TIMEOUT)) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= '0;
            mem_wdata <= '0;
            mem_addr  <= '0;
          end
          if (mem_ack) begin
            done <= 1'b1;
            if (lat_store) begin
              state <= S_IDLE;
            end else begin
              state    <= S_RESP;
              wb_valid <= (lat_rd != 5'd0);
              wb_rd    <= lat_rd;
              wb_data  <= ld_data;
            end
          end else if (cnt + 8'd1 == TIMEOUT) begin
            state       <= S_FAULT;
            fault       <= 1'b1;
            done        <= 1'b1;
            fault_cause <= 2'b11;
            bad_addr    <= lat_addr;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_RESP:  state <= S_IDLE;
        S_FAULT: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
